// File: rtl/fifo_byte_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_byte_unpacker
//  Purpose  : Drains 32-bit words from a synchronous FIFO one at a time and
//             emits each word as a valid/ready byte stream. The sink may
//             stall at any time. Counts the words that are fully delivered.
//  Options  : UNPACK_MSB_FIRST_EN - when defined, bytes are sent MSB first.
//             When undefined (default), bytes are sent LSB first.
//  Notes    : DATA_W must be an integer multiple of BYTE_W.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_byte_unpacker #(
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_cs,
   output logic              fifo_rd_en,
   output logic [BYTE_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam int NBYTES = DATA_W / BYTE_W;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      LOAD = 2'd2,
      SEND = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] shreg;
   logic [BYTE_W-1:0] byte_lane [NBYTES];
   logic              at_last;
   logic              handshake;

   // Slice the captured word into byte lanes; lane 0 is the first byte sent.
   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
`ifdef UNPACK_MSB_FIRST_EN
      assign byte_lane[gi] = shreg[DATA_W-1-gi*BYTE_W -: BYTE_W];
`else
      assign byte_lane[gi] = shreg[gi*BYTE_W +: BYTE_W];
`endif
   end

   assign at_last   = (idx == LAST_IDX);
   assign handshake = (state == SEND) && m_ready;

   // Byte output is decoded from the held word and index, so it cannot
   // change while a byte is stalled.
   assign m_data = byte_lane[idx];
   assign m_last = (state == SEND) && at_last;

   // State register; reset drops any partially sent word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Word capture, byte index advance and completed-word counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg    <= '0;
         idx      <= '0;
         word_cnt <= '0;
      end else begin
         if (state == LOAD) begin
            shreg <= fifo_data;
            idx   <= '0;
         end else if (handshake) begin
            if (at_last) begin
               word_cnt <= word_cnt + 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

   // Next-state logic and Moore-decoded FIFO/stream controls.
   always_comb begin
      state_nxt  = state;
      fifo_cs    = 1'b0;
      fifo_rd_en = 1'b0;
      m_valid    = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            fifo_cs    = 1'b1;
            fifo_rd_en = 1'b1;
            state_nxt  = LOAD;
         end
         LOAD: begin
            fifo_cs   = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            m_valid = 1'b1;
            if (handshake && at_last) begin
               state_nxt = fifo_empty ? IDLE : REQ;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
